// File: rtl/trap_entry_sequencer.sv
// Trap entry sequencer: picks the winning exception or interrupt beside MEM,
// captures epc/cause/tval/target/vector, then walks IDLE -> COMMIT -> FLUSH
// so the CSR file writes first and the pipeline flushes one cycle later.
module trap_entry_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            exc_valid,
  input  logic [4:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            irq_slot_valid,
  input  logic [XLEN-1:0] irq_slot_pc,
  input  logic            xret_flush,
  input  logic [11:0]     irq_pending,
  input  logic [1:0]      current_priv,
  input  logic            mstatus_mie,
  input  logic            mstatus_sie,
  input  logic [15:0]     medeleg,
  input  logic [11:0]     mideleg,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] stvec,
  output logic            busy,
  output logic            csr_trap_we,
  output logic            trap_to_s,
  output logic [XLEN-1:0] trap_epc,
  output logic [XLEN-1:0] trap_cause,
  output logic [XLEN-1:0] trap_tval,
  output logic            trap_flush,
  output logic [1:0]      trap_target_priv,
  output logic [XLEN-1:0] trap_vector
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            to_s_q, to_s_d;
  logic [1:0]      tpriv_q, tpriv_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] vector_q, vector_d;

  // Privilege decode: encoding 10 is folded into M.
  logic priv_m, priv_s, priv_u;
  assign priv_m = current_priv[1];
  assign priv_s = (current_priv == 2'b01);
  assign priv_u = (current_priv == 2'b00);

  logic [11:0] irq_en;
  logic [3:0]  irq_code;
  logic        irq_any;
  logic        irq_take;
  logic        exc_to_s;
  logic        irq_to_s;

  // Per-code enable: delegated codes go to S (never taken while in M), the rest to M.
  always_comb begin
    irq_en = '0;
    for (int n = 0; n < 12; n++) begin
      if (mideleg[n]) begin
        irq_en[n] = irq_pending[n] & ~priv_m & (priv_u | (priv_s & mstatus_sie));
      end else begin
        irq_en[n] = irq_pending[n] & (~priv_m | mstatus_mie);
      end
    end
  end

  // Fixed priority among enabled standard interrupts: MEI, MSI, MTI, SEI, SSI, STI.
  always_comb begin
    irq_code = 4'd0;
    if      (irq_en[11]) irq_code = 4'd11;
    else if (irq_en[3])  irq_code = 4'd3;
    else if (irq_en[7])  irq_code = 4'd7;
    else if (irq_en[9])  irq_code = 4'd9;
    else if (irq_en[1])  irq_code = 4'd1;
    else if (irq_en[5])  irq_code = 4'd5;
  end

  assign irq_any  = |(irq_en & 12'hAAA);
  assign irq_take = irq_slot_valid & ~exc_valid & ~xret_flush & irq_any;
  assign exc_to_s = ~priv_m & ~exc_cause[4] & medeleg[exc_cause[3:0]];
  assign irq_to_s = mideleg[irq_code];

  logic [XLEN-1:0] sel_tvec;
  logic [XLEN-1:0] tvec_base;
  logic            sel_s;

  // Next-state and capture logic; captures only load when leaving IDLE.
  always_comb begin
    state_d   = state_q;
    to_s_d    = to_s_q;
    tpriv_d   = tpriv_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    tval_d    = tval_q;
    vector_d  = vector_q;
    sel_s     = exc_valid ? exc_to_s : irq_to_s;
    sel_tvec  = sel_s ? stvec : mtvec;
    tvec_base = {sel_tvec[XLEN-1:2], 2'b00};
    case (state_q)
      IDLE: begin
        if (exc_valid | irq_take) begin
          state_d = COMMIT;
          to_s_d  = sel_s;
          tpriv_d = sel_s ? 2'b01 : 2'b11;
          if (exc_valid) begin
            epc_d    = exc_pc;
            cause_d  = {{(XLEN-5){1'b0}}, exc_cause};
            tval_d   = exc_tval;
            vector_d = tvec_base;
          end else begin
            epc_d    = irq_slot_pc;
            cause_d  = {1'b1, {(XLEN-5){1'b0}}, irq_code};
            tval_d   = '0;
            vector_d = (sel_tvec[1:0] == 2'b01)
                       ? tvec_base + {{(XLEN-6){1'b0}}, irq_code, 2'b00}
                       : tvec_base;
          end
        end
      end
      COMMIT:  state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers; reset abandons any sequence in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      to_s_q   <= 1'b0;
      tpriv_q  <= 2'b11;
      epc_q    <= '0;
      cause_q  <= '0;
      tval_q   <= '0;
      vector_q <= '0;
    end else begin
      state_q  <= state_d;
      to_s_q   <= to_s_d;
      tpriv_q  <= tpriv_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      tval_q   <= tval_d;
      vector_q <= vector_d;
    end
  end

  assign busy             = (state_q != IDLE);
  assign csr_trap_we      = (state_q == COMMIT);
  assign trap_flush       = (state_q == FLUSH);
  assign trap_to_s        = to_s_q;
  assign trap_target_priv = tpriv_q;
  assign trap_epc         = epc_q;
  assign trap_cause       = cause_q;
  assign trap_tval        = tval_q;
  assign trap_vector      = vector_q;

endmodule

// File: tb/tb_trap_entry_sequencer.sv
// Bench for trap_entry_sequencer: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a behavioural model.
module tb_trap_entry_sequencer;

  typedef struct packed {
    logic [1:0]  priv;
    logic        exc_valid;
    logic [4:0]  exc_cause;
    logic [31:0] exc_pc;
    logic [31:0] exc_tval;
    logic        slot;
    logic [31:0] slot_pc;
    logic        xret;
    logic [11:0] pend;
    logic        mie;
    logic        sie;
    logic [15:0] medeleg;
    logic [11:0] mideleg;
    logic [31:0] mtvec;
    logic [31:0] stvec;
  } stim_t;

  typedef struct packed {
    logic        to_s;
    logic [1:0]  tpriv;
    logic [31:0] epc;
    logic [31:0] cause;
    logic [31:0] tval;
    logic [31:0] vector;
  } rec_t;

  typedef struct packed {
    stim_t s;
    rec_t  e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        exc_valid, irq_slot_valid, xret_flush, mstatus_mie, mstatus_sie;
  logic [4:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval, irq_slot_pc, mtvec, stvec;
  logic [11:0] irq_pending, mideleg;
  logic [1:0]  current_priv;
  logic [15:0] medeleg;
  logic        busy, csr_trap_we, trap_to_s, trap_flush;
  logic [31:0] trap_epc, trap_cause, trap_tval, trap_vector;
  logic [1:0]  trap_target_priv;

  int asserts = 0;
  int failures = 0;

  trap_entry_sequencer #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .irq_slot_valid(irq_slot_valid), .irq_slot_pc(irq_slot_pc), .xret_flush(xret_flush),
    .irq_pending(irq_pending), .current_priv(current_priv),
    .mstatus_mie(mstatus_mie), .mstatus_sie(mstatus_sie),
    .medeleg(medeleg), .mideleg(mideleg), .mtvec(mtvec), .stvec(stvec),
    .busy(busy), .csr_trap_we(csr_trap_we), .trap_to_s(trap_to_s),
    .trap_epc(trap_epc), .trap_cause(trap_cause), .trap_tval(trap_tval),
    .trap_flush(trap_flush), .trap_target_priv(trap_target_priv), .trap_vector(trap_vector)
  );

  always #5 clk = ~clk;

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    s.priv = 2'b11;
    return s;
  endfunction

  function automatic rec_t mkRec(input logic to_s, input logic [31:0] epc, input logic [31:0] cause,
                                 input logic [31:0] tval, input logic [31:0] vector);
    rec_t r;
    r.to_s = to_s;
    r.tpriv = to_s ? 2'b01 : 2'b11;
    r.epc = epc;
    r.cause = cause;
    r.tval = tval;
    r.vector = vector;
    return r;
  endfunction

  // Behavioural reference: decides whether a trap is taken this cycle and what it looks like.
  function automatic bit modelEvent(input stim_t s, output rec_t r);
    int  prio[6] = '{11, 3, 7, 9, 1, 5};
    int  lvl;
    int  code = 0;
    bit  take = 0;
    bit  is_irq = 0;
    bit  to_s = 0;
    logic [31:0] tv, base, epc, cause, tval;
    epc = 0; cause = 0; tval = 0;
    lvl = (s.priv == 2'b00) ? 0 : (s.priv == 2'b01) ? 1 : 3;
    if (s.exc_valid) begin
      take = 1;
      to_s = (lvl != 3) && (s.exc_cause < 16) && s.medeleg[s.exc_cause[3:0]];
      epc = s.exc_pc;
      cause = 32'(s.exc_cause);
      tval = s.exc_tval;
    end else if (s.slot && !s.xret) begin
      for (int k = 0; k < 6 && !take; k++) begin
        code = prio[k];
        if (s.pend[code]) begin
          bit ok;
          bit dlg;
          dlg = s.mideleg[code];
          if (dlg) ok = (lvl == 0) || (lvl == 1 && s.sie);
          else     ok = (lvl != 3) || s.mie;
          if (ok) begin
            take = 1;
            is_irq = 1;
            to_s = dlg;
          end
        end
      end
      if (take) begin
        epc = s.slot_pc;
        cause = 32'h8000_0000 | 32'(code);
        tval = 0;
      end
    end
    tv = to_s ? s.stvec : s.mtvec;
    base = tv & ~32'd3;
    r = mkRec(to_s, epc, cause, tval,
              (is_irq && tv[1:0] == 2'b01) ? base + 32'(4 * code) : base);
    return take;
  endfunction

  task automatic applyStimulus(input stim_t s);
    current_priv   = s.priv;
    exc_valid      = s.exc_valid;
    exc_cause      = s.exc_cause;
    exc_pc         = s.exc_pc;
    exc_tval       = s.exc_tval;
    irq_slot_valid = s.slot;
    irq_slot_pc    = s.slot_pc;
    xret_flush     = s.xret;
    irq_pending    = s.pend;
    mstatus_mie    = s.mie;
    mstatus_sie    = s.sie;
    medeleg        = s.medeleg;
    mideleg        = s.mideleg;
    mtvec          = s.mtvec;
    stvec          = s.stvec;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkState(input string tag, input bit b, input bit we, input bit fl, input rec_t r);
    checkOutput({tag, ".busy"},   32'(busy), 32'(b));
    checkOutput({tag, ".we"},     32'(csr_trap_we), 32'(we));
    checkOutput({tag, ".flush"},  32'(trap_flush), 32'(fl));
    checkOutput({tag, ".to_s"},   32'(trap_to_s), 32'(r.to_s));
    checkOutput({tag, ".priv"},   32'(trap_target_priv), 32'(r.tpriv));
    checkOutput({tag, ".epc"},    trap_epc, r.epc);
    checkOutput({tag, ".cause"},  trap_cause, r.cause);
    checkOutput({tag, ".tval"},   trap_tval, r.tval);
    checkOutput({tag, ".vector"}, trap_vector, r.vector);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".busy"},  32'(busy), 0);
    checkOutput({tag, ".we"},    32'(csr_trap_we), 0);
    checkOutput({tag, ".flush"}, 32'(trap_flush), 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Event stimulus must already be applied in IDLE; walks COMMIT, FLUSH and back to IDLE.
  task automatic runTrap(input string tag, input rec_t r);
    tick();
    checkState({tag, ".commit"}, 1, 1, 0, r);
    applyStimulus(idleStim());
    tick();
    checkState({tag, ".flush"}, 1, 0, 1, r);
    tick();
    checkState({tag, ".idle"}, 0, 0, 0, r);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    applyStimulus(idleStim());
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  vec_t  tbl[8];
  rec_t  rst_rec;
  rec_t  m_rec, r_new, held;
  stim_t s;
  int    m_phase;

  initial begin
    rst_rec = mkRec(0, 0, 0, 0, 0);

    s = idleStim(); s.priv = 2'b00; s.exc_valid = 1; s.exc_cause = 8; s.exc_pc = 32'h400;
    s.exc_tval = 32'hBAD; s.medeleg = 16'h0100; s.stvec = 32'h8000_1000; s.mtvec = 32'h8000_0000;
    tbl[0] = '{s, mkRec(1, 32'h400, 8, 32'hBAD, 32'h8000_1000)};
    s.priv = 2'b11;
    tbl[1] = '{s, mkRec(0, 32'h400, 8, 32'hBAD, 32'h8000_0000)};
    s = idleStim(); s.priv = 2'b01; s.slot = 1; s.slot_pc = 32'h500; s.pend = 12'h880; s.mtvec = 32'h8000_0001;
    tbl[2] = '{s, mkRec(0, 32'h500, 32'h8000_000B, 0, 32'h8000_002C)};
    s = idleStim(); s.priv = 2'b01; s.slot = 1; s.slot_pc = 32'h600; s.pend = 12'h200;
    s.mideleg = 12'h200; s.sie = 1; s.stvec = 32'h8000_2001;
    tbl[3] = '{s, mkRec(1, 32'h600, 32'h8000_0009, 0, 32'h8000_2024)};
    s = idleStim(); s.priv = 2'b10; s.exc_valid = 1; s.exc_cause = 2; s.exc_pc = 32'h700;
    s.exc_tval = 32'h11; s.medeleg = 16'hFFFF; s.mtvec = 32'h10;
    tbl[4] = '{s, mkRec(0, 32'h700, 2, 32'h11, 32'h10)};
    s = idleStim(); s.priv = 2'b00; s.exc_valid = 1; s.exc_cause = 20; s.exc_pc = 32'h800;
    s.exc_tval = 32'h22; s.medeleg = 16'hFFFF; s.mtvec = 32'h101; s.stvec = 32'h9000;
    tbl[5] = '{s, mkRec(0, 32'h800, 32'h14, 32'h22, 32'h100)};
    s = idleStim(); s.priv = 2'b00; s.slot = 1; s.slot_pc = 32'h900; s.pend = 12'h080; s.mtvec = 32'hFFFF_FFFD;
    tbl[6] = '{s, mkRec(0, 32'h900, 32'h8000_0007, 0, 32'h18)};
    s = idleStim(); s.priv = 2'b11; s.mie = 1; s.slot = 1; s.slot_pc = 32'hA00; s.pend = 12'h202;
    s.mideleg = 12'h200; s.mtvec = 32'h4;
    tbl[7] = '{s, mkRec(0, 32'hA00, 32'h8000_0001, 0, 32'h4)};

    doReset();
    checkState("reset", 0, 0, 0, rst_rec);

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].s);
      runTrap($sformatf("vec%0d", i), tbl[i].e);
    end

    // Exception and interrupt together: exception first, interrupt once back in IDLE.
    s = idleStim(); s.mie = 1; s.exc_valid = 1; s.exc_cause = 8; s.exc_pc = 32'hB00; s.exc_tval = 32'h33;
    s.slot = 1; s.slot_pc = 32'hB04; s.pend = 12'h080; s.mtvec = 32'h40;
    applyStimulus(s);
    tick();
    checkState("both.commit", 1, 1, 0, mkRec(0, 32'hB00, 8, 32'h33, 32'h40));
    tick();
    checkState("both.flush", 1, 0, 1, mkRec(0, 32'hB00, 8, 32'h33, 32'h40));
    s.exc_valid = 0;
    applyStimulus(s);
    tick();
    checkIdle("both.gap");
    runTrap("both.irq", mkRec(0, 32'hB04, 32'h8000_0007, 0, 32'h40));

    // Interrupt deferred by xret_flush and by a missing slot, then taken.
    s = idleStim(); s.priv = 2'b00; s.slot = 1; s.slot_pc = 32'hC00; s.pend = 12'h020; s.xret = 1; s.mtvec = 32'h200;
    applyStimulus(s);
    tick();
    checkIdle("defer.xret");
    s.xret = 0; s.slot = 0;
    applyStimulus(s);
    tick();
    checkIdle("defer.noslot");
    s.slot = 1;
    applyStimulus(s);
    runTrap("defer.take", mkRec(0, 32'hC00, 32'h8000_0005, 0, 32'h200));

    // Delegated SEI blocked in S while SIE=0, taken once SIE=1.
    s = idleStim(); s.priv = 2'b01; s.slot = 1; s.slot_pc = 32'hD00; s.pend = 12'h200;
    s.mideleg = 12'h200; s.stvec = 32'h5000;
    applyStimulus(s);
    tick();
    checkIdle("sei.blocked");
    tick();
    checkIdle("sei.blocked2");
    s.sie = 1;
    applyStimulus(s);
    runTrap("sei.take", mkRec(1, 32'hD00, 32'h8000_0009, 0, 32'h5000));

    // Second exception while busy is ignored.
    applyStimulus(tbl[0].s);
    tick();
    checkState("busy.commit", 1, 1, 0, tbl[0].e);
    s = tbl[1].s; s.exc_cause = 5; s.exc_pc = 32'hE00;
    applyStimulus(s);
    tick();
    checkState("busy.flush", 1, 0, 1, tbl[0].e);
    applyStimulus(idleStim());
    tick();
    checkState("busy.idle", 0, 0, 0, tbl[0].e);

    // Reset during COMMIT: immediate clear and no later pulses.
    applyStimulus(tbl[3].s);
    tick();
    checkOutput("rstmid.we_before", 32'(csr_trap_we), 1);
    reset_n = 1'b0;
    #1;
    checkState("rstmid.during", 0, 0, 0, rst_rec);
    applyStimulus(idleStim());
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkIdle($sformatf("rstmid.after%0d", i));
    end

    // Randomized run against the reference model.
    doReset();
    m_rec = rst_rec;
    m_phase = 0;
    for (int i = 0; i < 600; i++) begin
      s.priv      = 2'($urandom);
      s.exc_valid = ($urandom_range(0, 3) == 0);
      s.exc_cause = 5'($urandom);
      s.exc_pc    = $urandom;
      s.exc_tval  = $urandom;
      s.slot      = $urandom_range(0, 1) == 1;
      s.slot_pc   = $urandom;
      s.xret      = ($urandom_range(0, 7) == 0);
      s.pend      = 12'($urandom);
      s.mie       = $urandom_range(0, 1) == 1;
      s.sie       = $urandom_range(0, 1) == 1;
      s.medeleg   = 16'($urandom);
      s.mideleg   = 12'($urandom);
      s.mtvec     = $urandom;
      s.stvec     = $urandom;
      applyStimulus(s);
      if (m_phase == 0) begin
        if (modelEvent(s, r_new)) begin
          m_rec = r_new;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else begin
        m_phase = 0;
      end
      tick();
      held = m_rec;
      checkState($sformatf("rnd%0d", i), m_phase != 0, m_phase == 1, m_phase == 2, held);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
